thread_fetch_sched: RTL and testbench

Parametrised multithreaded fetch scheduler for the barrel RISC-V core: holds one program counter per hardware thread, selects the thread that fetches each cycle, and applies branch/jump redirects returned from the MEM stage. It sits in front of the instruction memory and generalises the fixed 4-thread PC rotation to `NUM_THREADS` threads. It adds a per-thread active mask, stall-independent redirects and error reporting.

---
 rtl/thread_fetch_sched.sv | 112 +++++++++++
 tb/tb_thread_fetch_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/thread_fetch_sched.sv
// Barrel fetch scheduler: one PC per hardware thread, per-cycle thread select,
// MEM-stage redirects, sticky malformed-redirect flag. Option: THREAD_SKIP_EN.
module thread_fetch_sched #(
  parameter int NUM_THREADS     = 4,
  parameter int PC_WIDTH        = 32,
  parameter int PC_STEP         = 4,
  parameter int RESET_PC_STRIDE = 4,
  parameter int TID_W           = $clog2(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pc_en,
  input  logic [NUM_THREADS-1:0] thread_active,
  input  logic                   redirect_valid,
  input  logic [NUM_THREADS-1:0] redirect_thread,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   fetch_valid,
  output logic [PC_WIDTH-1:0]    fetch_pc,
  output logic [NUM_THREADS-1:0] fetch_thread,
  output logic [TID_W-1:0]       fetch_tid,
  output logic                   redirect_err
);

  typedef logic [TID_W-1:0] tid_t;

  logic [PC_WIDTH-1:0] pc_q [NUM_THREADS];
  tid_t                cur_q;
  tid_t                cur_nxt;
  logic                err_q;
  logic                rt_one_hot;
  logic                rd_ok;
  logic                rd_bad;

  function automatic tid_t wrap_inc(input tid_t t);
    return (t == tid_t'(NUM_THREADS - 1)) ? '0 : t + tid_t'(1);
  endfunction

  // A redirect is well-formed only with exactly one target bit set.
  always_comb begin
    rt_one_hot = (redirect_thread != '0) &&
                 ((redirect_thread &
                   (redirect_thread - NUM_THREADS'(1))) == '0);
    rd_ok      = redirect_valid & rt_one_hot;
    rd_bad     = redirect_valid & ~rt_one_hot;
  end

`ifdef THREAD_SKIP_EN
  // Next slot goes to the first active thread after cur, cyclically;
  // with nothing active the pointer holds.
  always_comb begin
    tid_t idx;
    logic found;
    cur_nxt = cur_q;
    idx     = cur_q;
    found   = 1'b0;
    for (int j = 0; j < NUM_THREADS; j++) begin
      idx = wrap_inc(idx);
      if (!found && thread_active[idx]) begin
        cur_nxt = idx;
        found   = 1'b1;
      end
    end
  end
`else
  // Strict rotation keeps every thread on a fixed N-cycle cadence.
  always_comb begin
    cur_nxt = wrap_inc(cur_q);
  end
`endif

  // Slot outputs: everything registered except the fetch qualifier.
  always_comb begin
    fetch_valid  = pc_en & thread_active[cur_q];
    fetch_pc     = pc_q[cur_q];
    fetch_tid    = cur_q;
    fetch_thread = NUM_THREADS'(1) << cur_q;
    redirect_err = err_q;
  end

  // PC file: redirect overrides the sequential step on the same thread.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        pc_q[i] <= PC_WIDTH'(i * RESET_PC_STRIDE);
      end
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (rd_ok && redirect_thread[i]) begin
          pc_q[i] <= redirect_pc;
        end else if (fetch_valid && cur_q == tid_t'(i)) begin
          pc_q[i] <= pc_q[i] + PC_WIDTH'(PC_STEP);
        end
      end
    end
  end

  // Thread pointer and sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (pc_en) begin
        cur_q <= cur_nxt;
      end
      if (rd_bad) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_thread_fetch_sched.sv
// Self-checking bench for thread_fetch_sched (4 threads, 32-bit PC).
// Vector table, directed corner sequences, then random vs. reference model.
module tb_thread_fetch_sched;

  logic        clk;
  logic        reset_n;
  logic        pc_en;
  logic [3:0]  thread_active;
  logic        redirect_valid;
  logic [3:0]  redirect_thread;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [3:0]  fetch_thread;
  logic [1:0]  fetch_tid;
  logic        redirect_err;

  int checks = 0;
  int errors = 0;

  thread_fetch_sched #(
    .NUM_THREADS(4),
    .PC_WIDTH(32),
    .PC_STEP(4),
    .RESET_PC_STRIDE(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pc_en(pc_en),
    .thread_active(thread_active),
    .redirect_valid(redirect_valid),
    .redirect_thread(redirect_thread),
    .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc),
    .fetch_thread(fetch_thread),
    .fetch_tid(fetch_tid),
    .redirect_err(redirect_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        en;
    logic [3:0]  act;
    logic        rv;
    logic [3:0]  rt;
    logic [31:0] rpc;
    int          tid;
    logic [31:0] pc;
    logic        v;
  } vec_t;

  vec_t tbl[13];

  logic [31:0] m_pc[4];
  int          m_cur;
  logic        m_err;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int tid,
                         input logic [31:0] pc, input logic v,
                         input logic err);
    logic [3:0] oh;
    oh = 4'b0001 << tid;
    chk({tag, ".tid"}, 32'(fetch_tid), 32'(tid));
    chk({tag, ".pc"}, fetch_pc, pc);
    chk({tag, ".valid"}, 32'(fetch_valid), 32'(v));
    chk({tag, ".thread"}, 32'(fetch_thread), 32'(oh));
    chk({tag, ".err"}, 32'(redirect_err), 32'(err));
  endtask

  task automatic drive(input logic e, input logic [3:0] a, input logic v,
                       input logic [3:0] t, input logic [31:0] p);
    pc_en           = e;
    thread_active   = a;
    redirect_valid  = v;
    redirect_thread = t;
    redirect_pc     = p;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pc[i] = 32'(i * 4);
    m_cur = 0;
    m_err = 1'b0;
  endtask

  task automatic model_check(input string tag);
    chk_out(tag, m_cur, m_pc[m_cur],
            pc_en & thread_active[m_cur], m_err);
  endtask

  // Effect of one rising edge on the architectural state.
  task automatic model_edge();
    int  ones;
    bit  found;
    int  c;
    ones = $countones(redirect_thread);
    if (redirect_valid && ones != 1) m_err = 1'b1;
    if (pc_en && thread_active[m_cur]) m_pc[m_cur] = m_pc[m_cur] + 32'd4;
    if (redirect_valid && ones == 1)
      for (int i = 0; i < 4; i++)
        if (redirect_thread[i]) m_pc[i] = redirect_pc;
    if (pc_en) begin
`ifdef THREAD_SKIP_EN
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        c = (m_cur + k) % 4;
        if (!found && thread_active[c]) begin
          m_cur = c;
          found = 1'b1;
        end
      end
`else
      found = 1'b0;
      c     = 0;
      m_cur = (m_cur + 1) % 4;
`endif
    end
  endtask

  initial begin
    int          sk_tid[5];
    logic [31:0] sk_pc[5];
    logic        sk_v[5];
    int          n_sk;

    reset_n         = 1'b0;
    pc_en           = 1'b1;
    thread_active   = 4'hE;
    redirect_valid  = 1'b0;
    redirect_thread = 4'h0;
    redirect_pc     = 32'h0;
    #1;
    chk_out("reset_inact0", 0, 32'h0, 1'b0, 1'b0);
    thread_active = 4'hF;
    #1;
    chk_out("reset_act0", 0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    do_reset();

    // Rotation, same-edge redirect, stalled redirect.
    tbl[0]  = '{1'b1, 4'hF, 1'b0, 4'h0, 32'h0,   0, 32'h0,   1'b1};
    tbl[1]  = '{1'b1, 4'hF, 1'b0, 4'h0, 32'h0,   1, 32'h4,   1'b1};
    tbl[2]  = '{1'b1, 4'hF, 1'b1, 4'h4, 32'h100, 2, 32'h8,   1'b1};
    tbl[3]  = '{1'b1, 4'hF, 1'b0, 4'h0, 32'h0,   3, 32'hC,   1'b1};
    tbl[4]  = '{1'b1, 4'hF, 1'b0, 4'h0, 32'h0,   0, 32'h4,   1'b1};
    tbl[5]  = '{1'b1, 4'hF, 1'b0, 4'h0, 32'h0,   1, 32'h8,   1'b1};
    tbl[6]  = '{1'b1, 4'hF, 1'b0, 4'h0, 32'h0,   2, 32'h100, 1'b1};
    tbl[7]  = '{1'b1, 4'hF, 1'b0, 4'h0, 32'h0,   3, 32'h10,  1'b1};
    tbl[8]  = '{1'b0, 4'hF, 1'b1, 4'h1, 32'h40,  0, 32'h8,   1'b0};
    tbl[9]  = '{1'b0, 4'hF, 1'b0, 4'h0, 32'h0,   0, 32'h40,  1'b0};
    tbl[10] = '{1'b0, 4'hF, 1'b0, 4'h0, 32'h0,   0, 32'h40,  1'b0};
    tbl[11] = '{1'b1, 4'hF, 1'b0, 4'h0, 32'h0,   0, 32'h40,  1'b1};
    tbl[12] = '{1'b1, 4'hF, 1'b0, 4'h0, 32'h0,   1, 32'hC,   1'b1};
    for (int r = 0; r < 13; r++) begin
      drive(tbl[r].en, tbl[r].act, tbl[r].rv, tbl[r].rt, tbl[r].rpc);
      chk_out($sformatf("vec%0d", r), tbl[r].tid, tbl[r].pc, tbl[r].v, 1'b0);
      tick();
    end

    // Active mask 1010.
    do_reset();
`ifdef THREAD_SKIP_EN
    n_sk = 5;
    sk_tid = '{0, 1, 3, 1, 3};
    sk_pc  = '{32'h0, 32'h4, 32'hC, 32'h8, 32'h10};
    sk_v   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`else
    n_sk = 5;
    sk_tid = '{0, 1, 2, 3, 0};
    sk_pc  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0};
    sk_v   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
    for (int r = 0; r < n_sk; r++) begin
      drive(1'b1, 4'hA, 1'b0, 4'h0, 32'h0);
      chk_out($sformatf("mask%0d", r), sk_tid[r], sk_pc[r], sk_v[r], 1'b0);
      tick();
    end

    // PC wrap after redirect to the top of the address space.
    do_reset();
    drive(1'b1, 4'hF, 1'b1, 4'h2, 32'hFFFF_FFFC);
    tick();
    drive(1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    chk_out("wrap_redir", 1, 32'hFFFF_FFFC, 1'b1, 1'b0);
    for (int r = 0; r < 4; r++) tick();
    drive(1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    chk_out("wrap_next", 1, 32'h0, 1'b1, 1'b0);
    tick();

    // Multi-hot redirect: ignored, sticky error until reset.
    do_reset();
    drive(1'b1, 4'hF, 1'b1, 4'h6, 32'h55);
    chk_out("bad_pre", 0, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    chk_out("bad_t1", 1, 32'h4, 1'b1, 1'b1);
    tick();
    drive(1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    chk_out("bad_t2", 2, 32'h8, 1'b1, 1'b1);
    tick();
    drive(1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    chk_out("bad_t3", 3, 32'hC, 1'b1, 1'b1);
    reset_n = 1'b0;
    #1;
    chk_out("bad_rst", 0, 32'h0, 1'b1, 1'b0);
    tick();

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int n = 0; n < 400; n++) begin
      logic [3:0] rt;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 7) rt = 4'b0001 << $urandom_range(0, 3);
      else if (sel == 7) rt = 4'h0;
      else rt = 4'($urandom_range(0, 15));
      drive($urandom_range(0, 4) != 0,
            ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
            $urandom_range(0, 9) < 3 && !(n < 200 && sel >= 7),
            rt, $urandom);
      model_check($sformatf("rnd%0d", n));
      model_edge();
      tick();
      if (n == 250) begin
        reset_n = 1'b0;
        #1;
        model_reset();
        model_check("rnd_rst");
        tick();
        reset_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
